mem_responder: RTL

- Target-side responder for the ce/wr/rd command interface driven by our bench stimulus and checked by our SVA properties.
- Accepts chip-enabled write, read, or combined write+read commands into a small on-chip register array.
- Returns write acknowledge, read data with a configurable read latency, and range errors.
- Provides a cycle-exact, assertion-checkable target, so properties such as "$fell(rst) |=> ..." and ce/wr/rd handshake checks have a real DUT to bind to.

---
 rtl/mem_responder.sv | 133 +++++++++++++
 1 files changed

// File: rtl/mem_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_responder: ce/wr/rd command target with register array, latency pipe |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module mem_responder #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 12,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic              wr,
  input  logic              rd,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              wack,
  output logic              err,
  output logic              busy
);

  localparam int c_CNT_W = $clog2(RD_LAT + 1);
  localparam int c_IDX_W = (DEPTH < 2) ? 1 : $clog2(DEPTH);
  // One extra bit so DEPTH == 2**ADDR_W is still representable.
  localparam logic [ADDR_W:0] c_DEPTH = (ADDR_W+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WRITE   = 2'd1,
    S_RD_WAIT = 2'd2,
    S_ERR     = 2'd3
  } state_t;

  state_t               r_state;
  logic [c_IDX_W-1:0]   r_idx;
  logic [DATA_W-1:0]    r_wdata;
  logic                 r_rd;
  logic [c_CNT_W-1:0]   r_cnt;
  logic [DATA_W-1:0]    r_mem [DEPTH];
  logic [DATA_W-1:0]    r_rdata;
  logic                 r_rvalid;
  logic                 r_wack;
  logic                 r_err;
  logic                 r_busy;

  logic w_accept;
  logic w_oor;

  assign w_accept = (r_state == S_IDLE) && ce && (wr || rd);
  assign w_oor    = ({1'b0, addr} >= c_DEPTH);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_idx    <= '0;
      r_wdata  <= '0;
      r_rd     <= 1'b0;
      r_cnt    <= '0;
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
      r_wack   <= 1'b0;
      r_err    <= 1'b0;
      r_busy   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      r_rvalid <= 1'b0;
      r_wack   <= 1'b0;
      r_err    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            // Out-of-range index is never used: ERR skips the array entirely.
            r_idx   <= addr[c_IDX_W-1:0];
            r_wdata <= wdata;
            r_rd    <= rd;
            r_busy  <= 1'b1;
            if (w_oor) begin
              r_state <= S_ERR;
            end else if (wr) begin
              r_state <= S_WRITE;
            end else begin
              r_state <= S_RD_WAIT;
              r_cnt   <= c_CNT_W'(RD_LAT);
            end
          end
        end
        S_ERR: begin
          r_err   <= 1'b1;
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        S_WRITE: begin
          r_mem[r_idx] <= r_wdata;
          r_wack       <= 1'b1;
          if (r_rd) begin
            r_state <= S_RD_WAIT;
            r_cnt   <= c_CNT_W'(RD_LAT);
          end else begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        S_RD_WAIT: begin
          if (r_cnt == c_CNT_W'(1)) begin
            r_rdata  <= r_mem[r_idx];
            r_rvalid <= 1'b1;
            r_state  <= S_IDLE;
            r_busy   <= 1'b0;
          end
          r_cnt <= r_cnt - c_CNT_W'(1);
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign rdata  = r_rdata;
  assign rvalid = r_rvalid;
  assign wack   = r_wack;
  assign err    = r_err;
  assign busy   = r_busy;

endmodule
`default_nettype wire
